// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit-side blocks.
package uart_pkg;
  localparam int BYTE_W = 8;
  localparam int RR_MAX = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } arb_state_t;

  // First set bit of valid at or after ptr+1, wrapping at n (n <= RR_MAX).
  function automatic logic [3:0] rr_pick(input logic [RR_MAX-1:0] valid,
                                         input logic [3:0] ptr, input int n);
    logic [3:0] pick;
    logic       found;
    int         c;
    pick  = ptr;
    found = 1'b0;
    for (int k = 1; k <= RR_MAX; k++) begin
      c = (int'(ptr) + k) % n;
      if (!found && (k <= n) && valid[c[3:0]]) begin
        pick  = 4'(c);
        found = 1'b1;
      end
    end
    return pick;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: request vector + last winner -> one-hot grant and index.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);
  logic [RR_MAX-1:0] w_req_ext;
  logic [3:0]        w_pick;

  assign w_req_ext = RR_MAX'(i_req);
  assign w_pick    = rr_pick(w_req_ext, 4'(i_ptr), NUM_REQ);
  assign o_any     = |i_req;
  assign o_idx     = IDX_W'(w_pick);
  assign o_grant   = o_any ? (NUM_REQ'(1) << o_idx) : '0;
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte streams, one byte in flight.
// Define UART_ARB_LOCK_EN to keep the grant with one requester until its req_last byte.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int CNT_W   = 16,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]         data_send,
  output logic                      ena_tx,
  input  logic                      tx_done,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      grant_valid,
  output logic                      busy,
  output logic [CNT_W-1:0]          byte_count
);
  arb_state_t         r_state;
  arb_state_t         w_next;
  logic [BYTE_W-1:0]  r_hold_data;
  logic               r_hold_valid;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_grant_idx;
  logic [CNT_W-1:0]   r_byte_count;
  logic               w_lock;
  logic [NUM_REQ-1:0] w_arb_grant;
  logic [IDX_W-1:0]   w_arb_idx;
  logic               w_arb_any;
  logic               w_owner_valid;
  logic               w_load;
  logic [IDX_W-1:0]   w_load_idx;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_any   (w_arb_any)
  );

  assign w_owner_valid = req_valid[r_grant_idx];

`ifdef UART_ARB_LOCK_EN
  logic r_lock;
  logic w_load_last;
  assign w_load_last = req_last[w_load_idx];
  always_ff @(posedge clk) begin
    if (!nrst)       r_lock <= 1'b0;
    else if (w_load) r_lock <= ~w_load_last;
  end
  assign w_lock      = r_lock;
  assign grant_valid = (r_state != IDLE);
`else
  logic w_unused_last;
  assign w_unused_last = ^req_last;
  assign w_lock        = 1'b0;
  assign grant_valid   = (r_state == SEND);
`endif

  always_ff @(posedge clk) begin
    if (!nrst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_arb_any) w_next = SEND;
      SEND: begin
        if (tx_done) begin
          if (w_lock) w_next = w_owner_valid ? SEND : HOLD;
          else        w_next = w_arb_any ? SEND : IDLE;
        end
      end
      HOLD:    if (w_owner_valid) w_next = SEND;
      default: w_next = IDLE;
    endcase
  end

  // A locked grant serves only the current owner; otherwise the arbiter picks.
  always_comb begin
    w_load     = 1'b0;
    w_load_idx = w_arb_idx;
    req_ready  = '0;
    if (nrst) begin
      case (r_state)
        IDLE: begin
          w_load    = w_arb_any;
          req_ready = w_arb_grant;
        end
        SEND: begin
          if (tx_done && w_lock) begin
            w_load     = w_owner_valid;
            w_load_idx = r_grant_idx;
            req_ready  = w_owner_valid ? (NUM_REQ'(1) << r_grant_idx) : '0;
          end else if (tx_done) begin
            w_load    = w_arb_any;
            req_ready = w_arb_grant;
          end
        end
        HOLD: begin
          w_load     = w_owner_valid;
          w_load_idx = r_grant_idx;
          req_ready  = w_owner_valid ? (NUM_REQ'(1) << r_grant_idx) : '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_hold_data  <= '0;
      r_hold_valid <= 1'b0;
      r_rr_ptr     <= IDX_W'(NUM_REQ - 1);
      r_grant_idx  <= '0;
      r_byte_count <= '0;
    end else begin
      r_hold_valid <= (w_next == SEND);
      if (tx_done) r_byte_count <= r_byte_count + CNT_W'(1);
      if (w_load) begin
        r_hold_data <= req_data[BYTE_W*w_load_idx +: BYTE_W];
        r_rr_ptr    <= w_load_idx;
        r_grant_idx <= w_load_idx;
      end
    end
  end

  assign data_send  = r_hold_data;
  assign ena_tx     = r_hold_valid;
  assign grant_idx  = r_grant_idx;
  assign busy       = (r_state != IDLE);
  assign byte_count = r_byte_count;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural UART + requester model, randomized and directed traffic.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int CW = 4;
  localparam int BT = 2;
  localparam int FL = 10 * BT;
`ifdef UART_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            nrst;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic [7:0]      data_send;
  logic            ena_tx;
  logic            tx_done;
  logic [1:0]      grant_idx;
  logic            grant_valid;
  logic            busy;
  logic [CW-1:0]   byte_count;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .CNT_W(CW)) dut (
    .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .data_send(data_send),
    .ena_tx(ena_tx), .tx_done(tx_done), .grant_idx(grant_idx),
    .grant_valid(grant_valid), .busy(busy), .byte_count(byte_count)
  );

  int checks = 0;
  int failures = 0;

  // Transaction-level model: is a byte in flight, who owns it, is a packet lock pending.
  bit         m_inflight, m_lock;
  int         m_owner, m_last, m_count, m_win;
  logic [7:0] m_data;
  logic [7:0] sb[$];

  // Behavioural UART.
  int         u_cnt = -1;
  int         u_idle_starts = 0;
  logic [7:0] u_log[$];
  bit         snap_ena;

  // Requester byte queues: {gap[6:0], last, data}.
  logic [15:0] qm[NR][32];
  int          qh[NR], qt[NR], wt[NR];
  bit          pres[NR];
  bit          cmp_on = 1'b0;
  int          r0_pulses = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_win();
    int c;
    if (nrst !== 1'b1) return -1;
    if (m_inflight && tx_done !== 1'b1) return -1;
    if (m_lock) return (req_valid[m_owner[1:0]] === 1'b1) ? m_owner : -1;
    for (int k = 1; k <= NR; k++) begin
      c = (m_last + k) % NR;
      if (req_valid[c[1:0]] === 1'b1) return c;
    end
    return -1;
  endfunction

  task automatic model_step();
    m_win = exp_win();
    if (nrst !== 1'b1) begin
      m_inflight = 0; m_lock = 0; m_owner = 0; m_last = NR - 1; m_count = 0; m_data = 8'h00;
      sb.delete();
    end else begin
      if (tx_done) m_count++;
      if (m_win >= 0) begin
        m_data     = req_data[8*m_win +: 8];
        m_inflight = 1;
        m_owner    = m_win;
        m_last     = m_win;
        m_lock     = LOCK && !req_last[m_win];
        sb.push_back(m_data);
      end else if (m_inflight && tx_done) begin
        m_inflight = 0;
      end
    end
  endtask

  task automatic uart_step();
    logic [8:0] exp;
    tx_done = 1'b0;
    if (nrst !== 1'b1) begin
      u_cnt = -1;
      return;
    end
    if (u_cnt < 0) begin
      if (snap_ena) begin u_cnt = 0; u_idle_starts++; end
    end else if (u_cnt == FL - 1) begin
      u_cnt = snap_ena ? 0 : -1;
    end else begin
      u_cnt++;
    end
    if (u_cnt == BT) begin
      u_log.push_back(data_send);
      exp = (sb.size() > 0) ? {1'b0, sb.pop_front()} : 9'h100;
      chk("uart_byte", 32'({1'b0, data_send}), 32'(exp));
    end
    if (u_cnt == FL - 3) tx_done = 1'b1;
  endtask

  task automatic stim_step();
    for (int i = 0; i < NR; i++) begin
      if (pres[i] && m_win == i) begin
        pres[i] = 0; qh[i]++; wt[i] = 0;
      end
      if (!pres[i] && qh[i] != qt[i]) begin
        if (wt[i] >= int'(qm[i][qh[i]][15:9])) pres[i] = 1;
        else wt[i]++;
      end
      req_valid[i]       = pres[i];
      req_data[8*i +: 8] = pres[i] ? qm[i][qh[i]][7:0] : 8'h00;
      req_last[i]        = pres[i] ? qm[i][qh[i]][8] : 1'b0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    snap_ena = ena_tx;
    @(posedge clk);
    #1;
    model_step();
    uart_step();
    stim_step();
  endtask

  task automatic push(input int i, input logic [7:0] d, input bit last, input int gap);
    if (qh[i] == qt[i]) begin qh[i] = 0; qt[i] = 0; end
    qm[i][qt[i]] = {7'(gap), last, d};
    qt[i]++;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    for (int i = 0; i < NR; i++) begin qh[i] = 0; qt[i] = 0; wt[i] = 0; pres[i] = 0; end
    cycle();
    nrst = 1'b1;
    u_log.delete();
    u_idle_starts = 0;
    r0_pulses = 0;
  endtask

  function automatic bit quiet();
    bit q;
    q = (u_cnt < 0) && (ena_tx === 1'b0) && (busy === 1'b0);
    for (int i = 0; i < NR; i++) if (pres[i] || qh[i] != qt[i]) q = 0;
    return q;
  endfunction

  task automatic wait_idle();
    int n;
    bit done;
    n = 0;
    done = 0;
    while (!done && n < 3000) begin
      if (m_lock && qh[m_owner] == qt[m_owner] && !pres[m_owner])
        push(m_owner, 8'($urandom_range(0, 255)), 1'b1, 0);
      cycle();
      n++;
      done = quiet();
    end
    chk("idle_reached", 32'(done), 32'd1);
  endtask

  always @(negedge clk) begin : cmp
    int w;
    logic [NR-1:0] er;
    if (cmp_on) begin
      w  = exp_win();
      er = (w >= 0) ? NR'(1 << w) : '0;
      if (req_ready[0] === 1'b1) r0_pulses++;
      chk("req_ready",   32'(req_ready),   32'(er));
      chk("ena_tx",      32'(ena_tx),      32'(m_inflight));
      chk("data_send",   32'(data_send),   32'(m_data));
      chk("grant_idx",   32'(grant_idx),   32'(m_owner));
      chk("grant_valid", 32'(grant_valid), 32'(LOCK ? (m_inflight || m_lock) : m_inflight));
      chk("busy",        32'(busy),        32'(m_inflight || m_lock));
      chk("byte_count",  32'(byte_count),  32'(m_count % (1 << CW)));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    nrst = 1'b0; tx_done = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
    do_reset();
    cmp_on = 1'b1;
    chk("reset_byte_count", 32'(byte_count), 32'd0);
    chk("reset_ena_tx", 32'(ena_tx), 32'd0);
    chk("reset_grant_idx", 32'(grant_idx), 32'd0);

    // Single byte.
    push(0, 8'hA5, 1'b1, 0);
    wait_idle();
    chk("single_frames", 32'(u_log.size()), 32'd1);
    chk("single_byte", 32'(u_log[0]), 32'hA5);
    chk("single_count", 32'(byte_count), 32'd1);
    chk("single_ready_pulses", 32'(r0_pulses), 32'd1);

    // Round-robin, back-to-back frames.
    do_reset();
    for (int i = 0; i < NR; i++) push(i, 8'(8'h10 + i), 1'b1, 0);
    wait_idle();
    for (int i = 0; i < NR; i++) chk("rr_order", 32'(u_log[i]), 32'(8'h10 + i));
    chk("rr_idle_starts", 32'(u_idle_starts), 32'd1);
    chk("rr_count", 32'(byte_count), 32'd4);

    // Packet on req1 with a gap before its second byte; req2 waiting throughout.
    do_reset();
    push(1, 8'h01, 1'b0, 0);
    push(1, 8'h02, 1'b0, FL + 4);
    push(1, 8'h03, 1'b1, 0);
    push(2, 8'hA2, 1'b1, 0);
    wait_idle();
    chk("pkt_frames", 32'(u_log.size()), 32'd4);
    chk("pkt_b0", 32'(u_log[0]), 32'h01);
    chk("pkt_b1", 32'(u_log[1]), LOCK ? 32'h02 : 32'hA2);
    chk("pkt_b2", 32'(u_log[2]), LOCK ? 32'h03 : 32'h02);
    chk("pkt_b3", 32'(u_log[3]), LOCK ? 32'hA2 : 32'h03);
    chk("pkt_idle_starts", 32'(u_idle_starts), LOCK ? 32'd2 : 32'd1);

    // Reset in the middle of data bit 4.
    do_reset();
    push(2, 8'h77, 1'b1, 0);
    n = 0;
    while (u_cnt != BT * 5 + 1 && n < 200) begin cycle(); n++; end
    chk("reset_point_reached", 32'(u_cnt == BT * 5 + 1), 32'd1);
    do_reset();
    chk("midrst_ena_tx", 32'(ena_tx), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < NR; i++) push(i, 8'(8'h20 + i), 1'b1, 0);
    wait_idle();
    chk("midrst_first", 32'(u_log[0]), 32'h20);

    // Counter wrap: 17 bytes with a 4-bit counter.
    do_reset();
    for (int k = 0; k < 17; k++) push(k % NR, 8'(k), 1'b1, 0);
    wait_idle();
    chk("wrap_frames", 32'(u_log.size()), 32'd17);
    chk("wrap_count", 32'(byte_count), 32'd1);

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NR; i++)
        if (qh[i] == qt[i] && !pres[i] && $urandom_range(0, 5) == 0)
          push(i, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : 0);
      cycle();
    end
    wait_idle();
    chk("rand_sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
